// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: FSM state
// encoding, transaction owner IDs and the owner selection rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  // Data wins by default; a starved fetch takes the port when both ask.
  function automatic arb_owner_e pick_owner(input logic want_i,
                                            input logic want_d,
                                            input logic starved);
    if (want_d && !(want_i && starved)) return OWN_D;
    return OWN_I;
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive fetch losses; at_max flags that the
// next contended grant must go to fetch.
module mem_arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rstn,   // synchronous, active-high
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt;

  // Count contended fetch losses, saturating; a fetch grant clears it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch stage (read-only) and
// the memory stage (read/write). One transaction in flight at a time;
// data wins unless fetch has lost STARVE_MAX contended grants in a row.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rstn,       // synchronous, active-high
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_rvalid,
  output logic            i_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_rvalid,
  output logic            d_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_rvalid
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, pick;
  logic       grant, done, deliver;
  logic       at_max, cnt_inc, cnt_clr;

  // Next-state, grant and completion decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    grant   = 1'b0;
    done    = 1'b0;
    pick    = pick_owner(i_req, d_req, at_max);
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Responses outside WAIT (stale ones after reset included) never reach here.
        if (mem_rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state plus the request captured at grant time, held until the next grant.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= pick;
        if (pick == OWN_D) begin
          mem_we    <= d_we;
          mem_be    <= d_be;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_be    <= '1;
          mem_addr  <= i_addr;
          mem_wdata <= '0;
        end
      end
    end
  end

  // Contended data wins feed the starvation count; any fetch grant resets it.
  assign cnt_inc = grant & i_req & d_req & (pick == OWN_D);
  assign cnt_clr = grant & (pick == OWN_I);

  mem_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rstn   (rstn),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .at_max (at_max)
  );

  // Reset suppresses any completion or issue seen in the reset cycle itself.
  assign deliver  = done & ~rstn;
  assign mem_req  = (state_q == ISSUE) & ~rstn;

  assign i_rvalid = deliver & (owner_q == OWN_I);
  assign d_rvalid = deliver & (owner_q == OWN_D);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;
  assign i_stall  = i_req & ~i_rvalid;
  assign d_stall  = d_req & ~d_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory responder with variable
// latency, per-cycle comparison against a transaction-phase model, directed
// scenarios with literal expectations and a randomized two-requester phase.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    d_be;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_rvalid, d_rvalid, i_stall, d_stall;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_rvalid;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] b);
    for (int k = 0; k < 4; k++) if (b[k]) o[8*k +: 8] = w[8*k +: 8];
    return o;
  endfunction

  // Memory contents as seen by the responder, and the requesters' own view.
  logic [31:0] mem    [16];
  logic [31:0] shadow [16];

  // Memory responder.
  int          lat = 1;
  bit          lat_rand = 0;
  bit          spur_en = 0;
  int          pend = 0;
  int          mem_req_cnt = 0;
  logic [3:0]  r_idx;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;

  // Behavioural model: transaction phase 0 idle, 1 issue, 2 wait.
  int          m_phase = 0;
  int          m_starve = 0;
  bit          m_owner_d = 0;
  bit          m_valid = 0;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;

  always @(negedge clk) begin
    if (mem_req) begin
      pend = lat_rand ? int'($urandom_range(1, 4)) : lat;
      r_idx = mem_addr[5:2];
      r_we = mem_we;
      r_be = mem_be;
      r_wdata = mem_wdata;
      mem_req_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = mem[r_idx];
        if (r_we) mem[r_idx] = merge(mem[r_idx], r_wdata, r_be);
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      mem_rvalid = spur_en && (m_phase != 2) && ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
  end

  // Per-cycle comparison against the model, then advance the model.
  always @(negedge clk) begin
    bit done, ei, ed;
    done = !rstn && (m_phase == 2) && mem_rvalid;
    ei = done && !m_owner_d;
    ed = done && m_owner_d;
    check("mem_req", mem_req, !rstn && (m_phase == 1));
    check("i_rvalid", i_rvalid, ei);
    check("d_rvalid", d_rvalid, ed);
    check("i_rdata", i_rdata, ei ? mem_rdata : 32'h0);
    check("d_rdata", d_rdata, ed ? mem_rdata : 32'h0);
    check("i_stall", i_stall, i_req && !ei);
    check("d_stall", d_stall, d_req && !ed);
    if (m_valid) begin
      check("mem_we", mem_we, m_we);
      check("mem_be", mem_be, m_be);
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
    end
    if (rstn) begin
      m_phase = 0; m_starve = 0; m_valid = 1;
      m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
    end else if (m_phase == 0) begin
      if (i_req || d_req) begin
        if (d_req && !(i_req && m_starve == SMAX)) begin
          m_owner_d = 1;
          if (i_req && m_starve < SMAX) m_starve++;
          m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
        end else begin
          m_owner_d = 0;
          m_starve = 0;
          m_we = 0; m_be = 4'hF; m_addr = i_addr; m_wdata = 0;
        end
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (mem_rvalid) begin
      m_phase = 0;
    end
  end

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rv(input bit want_d, output bit ok);
    ok = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (want_d ? d_rvalid : i_rvalid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic agent_i(input int n);
    for (int t = 0; t < n; t++) begin
      bit ok;
      int idx;
      drive_point();
      if ($urandom_range(0, 3) == 0) begin
        i_req = 0;
      end else begin
        idx = int'($urandom_range(0, 15));
        i_req = 1;
        i_addr = 32'h00400000 + 32'(idx * 4);
        wait_rv(0, ok);
        check("rand_i_done", ok, 1);
        if (ok) check("rand_i_data", i_rdata, shadow[idx]);
        if (!ok) i_req = 0;
      end
    end
    drive_point();
    i_req = 0;
  endtask

  task automatic agent_d(input int n);
    for (int t = 0; t < n; t++) begin
      bit ok;
      int idx;
      drive_point();
      if ($urandom_range(0, 3) == 0) begin
        d_req = 0;
      end else begin
        idx = int'($urandom_range(0, 15));
        d_req = 1;
        d_we = $urandom_range(0, 1);
        d_be = 4'($urandom_range(1, 15));
        d_wdata = $urandom;
        d_addr = 32'(idx * 4);
        wait_rv(1, ok);
        check("rand_d_done", ok, 1);
        if (ok) begin
          if (d_we) shadow[idx] = merge(shadow[idx], d_wdata, d_be);
          else check("rand_d_load", d_rdata, shadow[idx]);
        end
        if (!ok) d_req = 0;
      end
    end
    drive_point();
    d_req = 0;
  endtask

  initial begin
    bit ok;
    logic [9:0] seq;
    int first_i, cnt_rv, cnt_mr;
    logic [31:0] v;

    rstn = 1; i_req = 0; d_req = 0; d_we = 0; d_be = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    mem_rvalid = 0; mem_rdata = 0;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      mem[i] = v;
      shadow[i] = v;
    end

    // Reset held two cycles: everything quiet.
    @(negedge clk);
    check("t1_i_rvalid", i_rvalid, 0);
    check("t1_d_rvalid", d_rvalid, 0);
    @(negedge clk);
    check("t1_mem_be", mem_be, 0);
    check("t1_mem_addr", mem_addr, 0);
    check("t1_outs", {i_rdata, d_rdata}, 0);
    drive_point();
    rstn = 0;
    repeat (3) @(negedge clk);
    check("t1_no_mem_req", mem_req_cnt, 0);

    // Fetch only, latency 1.
    mem[0] = 32'h00500093; shadow[0] = 32'h00500093; lat = 1;
    drive_point();
    i_req = 1; i_addr = 32'h00400000;
    @(negedge clk);
    check("t2_stall_n", i_stall, 1);
    check("t2_memreq_n", mem_req, 0);
    @(negedge clk);
    check("t2_memreq_n1", mem_req, 1);
    check("t2_addr", mem_addr, 32'h00400000);
    check("t2_be", mem_be, 4'hF);
    check("t2_we", mem_we, 0);
    check("t2_stall_n1", i_stall, 1);
    @(negedge clk);
    check("t2_rvalid", i_rvalid, 1);
    check("t2_rdata", i_rdata, 32'h00500093);
    check("t2_stall_n2", i_stall, 0);
    drive_point();
    i_req = 0;

    // Partial store, then load it back.
    mem[4] = 32'h11223344; shadow[4] = 32'h11223344; lat = 2;
    drive_point();
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    check("t3_memreq", mem_req, 1);
    check("t3_issue", {mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 4'b0011, 32'h10, 32'hDEADBEEF});
    @(negedge clk);
    check("t3_wait", {mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 4'b0011, 32'h10, 32'hDEADBEEF});
    check("t3_no_ack_yet", d_rvalid, 0);
    @(negedge clk);
    check("t3_ack", d_rvalid, 1);
    check("t3_ack_data", d_rdata, 32'h11223344);
    shadow[4] = merge(shadow[4], 32'hDEADBEEF, 4'b0011);
    drive_point();
    d_we = 0; d_be = 4'hF; d_wdata = 0;
    wait_rv(1, ok);
    check("t3_load_done", ok, 1);
    check("t3_load_data", d_rdata, 32'h1122BEEF);
    drive_point();
    d_req = 0;

    // Continuous contention: fetch gets every fifth grant.
    drive_point();
    rstn = 1;
    drive_point();
    rstn = 0; lat = 1;
    i_req = 1; i_addr = 32'h20;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h24;
    seq = 0; first_i = 0;
    for (int n = 0; n < 10; n++) begin
      ok = 0;
      for (int k = 0; k < 64; k++) begin
        @(negedge clk);
        if (i_rvalid || d_rvalid) begin ok = 1; break; end
      end
      check("t4_done", ok, 1);
      seq[n] = i_rvalid;
      if (i_rvalid && first_i == 0) first_i = n + 1;
    end
    check("t4_grant_seq", seq, 10'b10_0001_0000);
    check("t4_first_fetch", first_i, 5);
    drive_point();
    i_req = 0; d_req = 0;

    // Reset during a long wait; the stale response must be ignored.
    repeat (2) drive_point();
    lat = 5;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h8;
    ok = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (mem_req) begin ok = 1; break; end
    end
    check("t5_issued", ok, 1);
    drive_point();
    drive_point();
    rstn = 1; d_req = 0;
    drive_point();
    rstn = 0;
    cnt_rv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (i_rvalid || d_rvalid) cnt_rv++;
    end
    check("t5_no_rvalid", cnt_rv, 0);
    mem[2] = 32'hCAFEF00D; shadow[2] = 32'hCAFEF00D; lat = 1;
    drive_point();
    i_req = 1; i_addr = 32'h8;
    wait_rv(0, ok);
    check("t5_served", ok, 1);
    check("t5_data", i_rdata, 32'hCAFEF00D);
    drive_point();
    i_req = 0;

    // Data request withdrawn while waiting: still completes exactly once.
    mem[3] = 32'h0BADC0DE; shadow[3] = 32'h0BADC0DE; lat = 3;
    drive_point();
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'hC;
    ok = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (mem_req) begin ok = 1; break; end
    end
    check("t6_issued", ok, 1);
    drive_point();
    d_req = 0;
    cnt_rv = 0; cnt_mr = 0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (d_rvalid) begin
        cnt_rv++;
        check("t6_data", d_rdata, 32'h0BADC0DE);
      end
      if (mem_req) cnt_mr++;
      @(negedge clk);
    end
    check("t6_one_rvalid", cnt_rv, 1);
    check("t6_no_extra_req", cnt_mr, 0);

    // Randomized traffic from both stages with spurious responses.
    lat_rand = 1; spur_en = 1;
    fork
      agent_i(300);
      agent_d(300);
    join
    spur_en = 0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
